// File: rtl/mem_pkg.sv
// Shared types, encodings and lane helpers for the memory-stage load/store unit.
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    DONE = 2'b11
  } state_t;

  function automatic logic [3:0] byte_strobe(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: return 4'b0001 << off;
      SIZE_HALF: return 4'b0011 << {off[1], 1'b0};
      default:   return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SIZE_BYTE: return {4{data[7:0]}};
      SIZE_HALF: return {2{data[15:0]}};
      default:   return data;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return off[0];
      default:   return off != 2'b00;
    endcase
  endfunction

  // Drops the low address bits that a misaligned half/word access cannot use
  function automatic logic [31:0] align_addr(input logic [1:0] size, input logic [31:0] addr);
    case (size)
      SIZE_BYTE: return addr;
      SIZE_HALF: return {addr[31:1], 1'b0};
      default:   return {addr[31:2], 2'b00};
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Load lane select plus sign/zero extension of the returned read word.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed lane and extend it to 32 bits
  always_comb begin
    byte_s = rdata[{offset, 3'b000} +: 8];
    half_s = rdata[{offset[1], 4'b0000} +: 16];
    case (size)
      SIZE_BYTE: result = {{24{~is_unsigned & byte_s[7]}}, byte_s};
      SIZE_HALF: result = {{16{~is_unsigned & half_s[15]}}, half_s};
      default:   result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: one outstanding request/grant bus transaction.
// Optional misaligned-access trap enabled by defining MEM_ACCESS_MISALIGN_TRAP_EN.
module mem_access_unit
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [1:0]  MemSizeM,
  input  logic [2:0]  funct3M,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignM
);

  state_t      state_r, state_nxt;
  logic        pending_s;
  logic        mis_s;
  logic [31:0] addr_s;
  logic [1:0]  off_r;
  logic [1:0]  size_r;
  logic        uns_r;
  logic [31:0] load_s;
  logic [1:0]  unused_funct3_s;

  assign unused_funct3_s = funct3M[1:0];
  assign pending_s = MemWriteM | (ResultSrcM == RESULT_SRC_LOAD);
  assign StallM    = pending_s & (state_r != DONE);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  logic misalign_r;

  assign mis_s     = misaligned(MemSizeM, ALUResultM[1:0]);
  assign addr_s    = ALUResultM;
  assign MisalignM = misalign_r;

  // Raised on the IDLE->DONE trap transition, so it covers the DONE cycle only
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      misalign_r <= 1'b0;
    end else begin
      misalign_r <= (state_r == IDLE) & pending_s & mis_s;
    end
  end
`else
  assign mis_s     = 1'b0;
  assign addr_s    = align_addr(MemSizeM, ALUResultM);
  assign MisalignM = 1'b0;
`endif

  load_align u_load_align (
    .rdata       (bus_rdata),
    .offset      (off_r),
    .size        (size_r),
    .is_unsigned (uns_r),
    .result      (load_s)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state logic; bus_we doubles as the captured store/load selector
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE: begin
        if (pending_s) begin
          state_nxt = mis_s ? DONE : REQ;
        end else begin
          state_nxt = IDLE;
        end
      end
      REQ: begin
        if (bus_gnt) begin
          state_nxt = bus_we ? DONE : WAIT;
        end else begin
          state_nxt = REQ;
        end
      end
      WAIT: begin
        if (bus_rvalid) begin
          state_nxt = DONE;
        end else begin
          state_nxt = WAIT;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus request fields and load control, captured on REQ entry and held until grant
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0000_0000;
      bus_wdata <= 32'h0000_0000;
      bus_wstrb <= 4'b0000;
      off_r     <= 2'b00;
      size_r    <= 2'b00;
      uns_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pending_s && !mis_s) begin
            bus_req   <= 1'b1;
            bus_we    <= MemWriteM;
            bus_addr  <= {addr_s[31:2], 2'b00};
            bus_wdata <= MemWriteM ? store_lanes(MemSizeM, WriteDataM) : 32'h0000_0000;
            bus_wstrb <= MemWriteM ? byte_strobe(MemSizeM, addr_s[1:0]) : 4'b0000;
            off_r     <= addr_s[1:0];
            size_r    <= MemSizeM;
            uns_r     <= funct3M[2];
          end
        end
        REQ: begin
          if (bus_gnt) begin
            bus_req <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Load result register, updated only when a load's data returns
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ReadDataM <= 32'h0000_0000;
    end else if ((state_r == WAIT) && bus_rvalid) begin
      ReadDataM <= load_s;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized
// accesses against a behavioural model (honours MEM_ACCESS_MISALIGN_TRAP_EN).
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] ALUResultM, WriteDataM;
  logic        MemWriteM;
  logic [1:0]  ResultSrcM, MemSizeM;
  logic [2:0]  funct3M;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;
  logic [31:0] ReadDataM;
  logic        StallM, MisalignM;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_rd = 32'h0;

  mem_access_unit dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .MemWriteM  (MemWriteM),
    .ResultSrcM (ResultSrcM),
    .MemSizeM   (MemSizeM),
    .funct3M    (funct3M),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_wstrb  (bus_wstrb),
    .bus_gnt    (bus_gnt),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .MisalignM  (MisalignM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_load(input logic [1:0] sz, input logic uns,
                                           input logic [1:0] off, input logic [31:0] rd);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (rd >> (32'd8 * off)) & 32'h0000_00FF;
      if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (rd >> (32'd8 * off)) & 32'h0000_FFFF;
      if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // One idle cycle with no access pending; stray rvalid must be ignored
  task automatic idle_cycle();
    MemWriteM  = 1'b0;
    ResultSrcM = 2'($urandom_range(0, 1) * 2);
    bus_rvalid = 1'($urandom_range(0, 1));
    bus_rdata  = $urandom;
    @(negedge clk);
    chk("idle_stall", {31'h0, StallM}, 32'h0);
    chk("idle_req", {31'h0, bus_req}, 32'h0);
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
  endtask

  // Full access starting in IDLE just after a rising edge
  task automatic access(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                        input int gdel, input int rdel, input logic rv_in_req);
    logic [1:0]  sz;
    logic        mis;
    logic [31:0] ea, xwd;
    logic [3:0]  xstrb;
    sz  = (size == 2'd3) ? 2'd2 : size;
    mis = (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'b00);
    ea  = addr;
    if (mis) ea = (sz == 2'd1) ? (addr & 32'hFFFF_FFFE) : (addr & 32'hFFFF_FFFC);
    xstrb = (sz == 2'd0) ? (4'b0001 << ea[1:0]) : (sz == 2'd1) ? (4'b0011 << (ea[1:0] & 2'b10)) : 4'hF;
    xwd   = (sz == 2'd0) ? (wd[7:0] * 32'h0101_0101) : (sz == 2'd1) ? (wd[15:0] * 32'h0001_0001) : wd;
    MemWriteM  = we;
    ResultSrcM = we ? 2'($urandom_range(0, 3)) : 2'b01;
    ALUResultM = addr;
    WriteDataM = wd;
    MemSizeM   = size;
    funct3M    = {uns, 2'($urandom_range(0, 3))};
    @(negedge clk);
    chk("idle_pend_stall", {31'h0, StallM}, 32'h1);
    chk("idle_pend_req", {31'h0, bus_req}, 32'h0);
    @(posedge clk); #1;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    if (mis) begin
      @(negedge clk);
      chk("trap_req", {31'h0, bus_req}, 32'h0);
      chk("trap_flag", {31'h0, MisalignM}, 32'h1);
      chk("trap_stall", {31'h0, StallM}, 32'h0);
      chk("trap_rdata", ReadDataM, exp_rd);
      @(posedge clk); #1;
      idle_cycle();
      return;
    end
`endif
    for (int i = 0; i <= gdel; i++) begin
      bus_gnt    = (i == gdel);
      bus_rvalid = rv_in_req ? 1'b1 : 1'($urandom_range(0, 1));
      bus_rdata  = $urandom;
      @(negedge clk);
      chk("req_req", {31'h0, bus_req}, 32'h1);
      chk("req_addr", bus_addr, ea & 32'hFFFF_FFFC);
      chk("req_we", {31'h0, bus_we}, {31'h0, we});
      chk("req_strb", {28'h0, bus_wstrb}, we ? {28'h0, xstrb} : 32'h0);
      if (we) chk("req_wdata", bus_wdata, xwd);
      chk("req_stall", {31'h0, StallM}, 32'h1);
      @(posedge clk); #1;
    end
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;
    if (!we) begin
      for (int i = 0; i <= rdel; i++) begin
        bus_rvalid = (i == rdel);
        bus_rdata  = (i == rdel) ? rd : $urandom;
        @(negedge clk);
        chk("wait_req", {31'h0, bus_req}, 32'h0);
        chk("wait_stall", {31'h0, StallM}, 32'h1);
        chk("wait_rdata_hold", ReadDataM, exp_rd);
        @(posedge clk); #1;
      end
      bus_rvalid = 1'b0;
      bus_rdata  = $urandom;
      exp_rd = exp_load(sz, uns, ea[1:0], rd);
    end
    @(negedge clk);
    chk("done_stall", {31'h0, StallM}, 32'h0);
    chk("done_req", {31'h0, bus_req}, 32'h0);
    chk("done_rdata", ReadDataM, exp_rd);
    chk("done_misalign", {31'h0, MisalignM}, 32'h0);
    @(posedge clk); #1;
    idle_cycle();
  endtask

  // Load abandoned by reset while in REQ (in_wait=0) or WAIT (in_wait=1)
  task automatic reset_mid(input logic in_wait);
    MemWriteM  = 1'b0;
    ResultSrcM = 2'b01;
    ALUResultM = 32'h0000_5004;
    MemSizeM   = 2'd2;
    funct3M    = 3'b010;
    @(posedge clk); #1;
    if (in_wait) begin
      bus_gnt = 1'b1;
      @(posedge clk); #1;
      bus_gnt = 1'b0;
    end
    @(negedge clk);
    chk("rst_pre_req", {31'h0, bus_req}, in_wait ? 32'h0 : 32'h1);
    chk("rst_pre_stall", {31'h0, StallM}, 32'h1);
    reset_n = 1'b0;
    #1;
    chk("rst_req", {31'h0, bus_req}, 32'h0);
    chk("rst_rdata", ReadDataM, 32'h0);
    chk("rst_addr", bus_addr, 32'h0);
    exp_rd = 32'h0;
    MemWriteM  = 1'b0;
    ResultSrcM = 2'b00;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_post_stall", {31'h0, StallM}, 32'h0);
    chk("rst_post_req", {31'h0, bus_req}, 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n    = 1'b0;
    ALUResultM = 32'h0;
    WriteDataM = 32'h0;
    MemWriteM  = 1'b0;
    ResultSrcM = 2'b00;
    MemSizeM   = 2'b00;
    funct3M    = 3'b000;
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = 32'h0;
    @(negedge clk);
    chk("reset_req", {31'h0, bus_req}, 32'h0);
    chk("reset_we", {31'h0, bus_we}, 32'h0);
    chk("reset_addr", bus_addr, 32'h0);
    chk("reset_wdata", bus_wdata, 32'h0);
    chk("reset_strb", {28'h0, bus_wstrb}, 32'h0);
    chk("reset_rdata", ReadDataM, 32'h0);
    chk("reset_misalign", {31'h0, MisalignM}, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle_cycle();

    // Store byte at 0x1003, granted on first REQ cycle
    access(1'b1, 2'd0, 1'b0, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0, 0, 1'b0);
    // Signed/unsigned byte loads with rvalid three cycles after grant
    access(1'b0, 2'd0, 1'b0, 32'h0000_2001, 32'h0, 32'h12F0_8034, 0, 3, 1'b0);
    chk("lb_const", ReadDataM, 32'hFFFF_FF80);
    access(1'b0, 2'd0, 1'b1, 32'h0000_2001, 32'h0, 32'h12F0_8034, 0, 3, 1'b0);
    chk("lbu_const", ReadDataM, 32'h0000_0080);
    access(1'b0, 2'd1, 1'b0, 32'h0000_2002, 32'h0, 32'h8001_7FFF, 1, 0, 1'b0);
    chk("lh_const", ReadDataM, 32'hFFFF_8001);
    access(1'b0, 2'd2, 1'b0, 32'h0000_2000, 32'h0, 32'h8001_7FFF, 0, 0, 1'b0);
    chk("lw_const", ReadDataM, 32'h8001_7FFF);
    // A store leaves the load result untouched
    access(1'b1, 2'd1, 1'b0, 32'h0000_2006, 32'h1234_BEEF, 32'h0, 2, 0, 1'b0);
    chk("store_keeps_rdata", ReadDataM, 32'h8001_7FFF);
    // Grant withheld five cycles with rvalid asserted throughout REQ
    access(1'b0, 2'd2, 1'b0, 32'h0000_2004, 32'h0, 32'h5566_7788, 5, 1, 1'b1);
    chk("gnt_wait_const", ReadDataM, 32'h5566_7788);
    reset_mid(1'b0);
    access(1'b0, 2'd0, 1'b1, 32'h0000_2002, 32'h0, 32'hA1B2_C3D4, 0, 0, 1'b0);
    reset_mid(1'b1);
    // Misaligned word load at 0x3002
    access(1'b0, 2'd2, 1'b0, 32'h0000_3002, 32'h0, 32'hCAFE_F00D, 0, 0, 1'b0);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    chk("lw_mis_const", ReadDataM, 32'h0);
`else
    chk("lw_mis_const", ReadDataM, 32'hCAFE_F00D);
`endif

    for (int n = 0; n < 60; n++) begin
      access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom, $urandom, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store unit sitting directly downstream of the EX/MEM pipeline register. It consumes the M-stage access fields and drives one outstanding transaction on a simple request/grant data-memory bus. It forms byte strobes and lane-replicated store data, and returns aligned, sign- or zero-extended load data to the MEM/WB path. While a transaction is in flight it stalls the pipeline.

## Interface
- No parameters; widths are fixed at 32-bit address and data.
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- ALUResultM  in  32  effective byte address
- WriteDataM  in  32  store data, right-justified
- MemWriteM  in  1  store access
- ResultSrcM  in  2  2'b01 marks a load
- MemSizeM  in  2  00 byte, 01 half, 10 word (11 treated as word)
- funct3M  in  3  bit 2 set means unsigned load (LBU/LHU)
- bus_req  out  1  request valid
- bus_we  out  1  1 = write
- bus_addr  out  32  word-aligned address, {addr[31:2],2'b00}
- bus_wdata  out  32  lane-replicated store data
- bus_wstrb  out  4  byte enables (0000 for loads)
- bus_gnt  in  1  request accepted this cycle
- bus_rvalid  in  1  read data valid
- bus_rdata  in  32  read word
- ReadDataM  out  32  extended load result, registered
- StallM  out  1  hold IF/ID/EX and the EX/MEM register
- MisalignM  out  1  misaligned-access flag; active only when the configuration macro below is defined

## Operation
- An access is pending when MemWriteM=1 or ResultSrcM=2'b01. If both are set, the store takes precedence.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE: on a pending access, capture addr, we, wstrb, wdata and the load control bits, then go to REQ.
  - REQ: bus_req=1. When bus_gnt=1, a store goes to DONE and a load goes to WAIT.
  - WAIT: on bus_rvalid=1, capture the extracted load data into ReadDataM and go to DONE.
  - DONE: always return to IDLE.
- StallM = pending && state!=DONE. It is combinational. The pipeline advances at the end of the DONE cycle, so each instruction is issued exactly once.
- Byte strobes and store data:
  - Byte: strobe 0001<<addr[1:0]; wdata = {4{WriteDataM[7:0]}}.
  - Half: strobe 0011<<{addr[1],1'b0}; wdata = {2{WriteDataM[15:0]}}.
  - Word: strobe 1111; wdata = WriteDataM.
- Load extraction:
  - Select byte rdata[8*addr[1:0]+:8] or half rdata[16*addr[1]+:16].
  - Zero-extend if funct3M[2]=1, else sign-extend. Word loads pass through unchanged.
- ReadDataM holds its value until the next load completes; stores do not alter it.
- bus_req, bus_addr, bus_we, bus_wdata and bus_wstrb are registered and stay stable from REQ entry until the grant cycle.

## Timing
- Reset values: state IDLE; bus_req 0, bus_we 0, bus_addr 0, bus_wdata 0, bus_wstrb 0; ReadDataM 0; MisalignM 0.
- Minimum latency:
  - Store: 3 cycles (IDLE, REQ with same-cycle gnt, DONE).
  - Load: 4 cycles (IDLE, REQ, WAIT with rvalid, DONE).
- bus_rvalid is ignored outside WAIT. A gnt and an rvalid arriving in the same REQ cycle count only the gnt.
- Unbounded gnt/rvalid waits keep StallM high. There is no timeout.
- Asserting reset_n mid-transaction drops bus_req immediately and returns to IDLE. The abandoned transaction is not reissued by this block.
- No access pending in IDLE: StallM=0 and the bus stays idle.

## Configuration
- Macro MEM_ACCESS_MISALIGN_TRAP_EN.
- Misaligned access is defined as half with addr[0]=1, or word with addr[1:0]!=0.
- With the macro defined:
  - A misaligned access goes IDLE→DONE with no bus request (one stall cycle).
  - MisalignM=1 for the DONE cycle only.
  - ReadDataM is unchanged.
- Without the macro:
  - MisalignM is tied 0.
  - The offending low address bits are cleared (half: addr[0]; word: addr[1:0]) and the access proceeds normally.

## Structure
- Shared package mem_pkg holds:
  - Size encodings: SIZE_BYTE, SIZE_HALF, SIZE_WORD.
  - RESULT_SRC_LOAD = 2'b01.
  - The FSM state enum.
- Sub-module load_align: combinational lane select plus sign/zero extension (rdata, offset, size, unsigned → 32-bit result).

## Test plan
- SB of 0x000000A5 at addr 0x1003, gnt on first REQ cycle → bus_wstrb=1000, bus_wdata=0xA5A5A5A5, StallM high for 2 cycles then low in DONE.
- LB at 0x2001 with rdata 0x12F0_8034, rvalid 3 cycles after gnt → ReadDataM=0xFFFFFF80. The same access as LBU → 0x00000080.
- LH at 0x2002 with rdata 0x8001_7FFF → ReadDataM=0xFFFF8001. LW → 0x80017FFF.
- gnt withheld 5 cycles → bus_req and bus_addr stable throughout and StallM stays high; rvalid asserted during REQ is ignored.
- reset_n pulled low in WAIT → bus_req=0 and ReadDataM=0 immediately; IDLE after release.
- LW at 0x3002: with the macro, no bus_req and MisalignM=1 for one cycle; without it, bus_addr=0x3000 and a normal load completes.
